pipe_skid_reg: RTL and testbench

- Parametrised elastic pipeline stage register for the CPU datapath, the successor to the plain clear/hold stage register.
- Replaces the bare flop with a valid/ready handshake and a 2-entry skid buffer, so upstream and downstream stalls decouple without a combinational ready path.
- Keeps per-stage clear and hold (stall) controls.
- Adds flush to squash in-flight contents on branch/exception.

---
 rtl/pipe_skid_reg_if.sv | 56 +++++
 rtl/pipe_skid_reg.sv | 122 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_if
// Handshake bundle for one elastic pipeline stage.
//
// Signals:
//   flush      squash buffered entries (driven by the pipeline controller)
//   hold       downstream stall; the stage treats it like out_ready=0
//   in_valid   upstream offers a word
//   in_ready   stage can accept a word
//   in         upstream payload, N bits
//   out_valid  out holds a valid entry
//   out_ready  downstream accepts out
//   out        head-entry payload, N bits
//   count      occupancy 0..2
//
// Modports:
//   master  the environment side (upstream + downstream + controller)
//   slave   the stage itself
// -----------------------------------------------------------------------------
interface pipe_skid_reg_if #(
    parameter int N = 32
);
    logic         flush;
    logic         hold;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic [1:0]   count;

    modport master (
        output flush,
        output hold,
        output in_valid,
        input  in_ready,
        output in,
        input  out_valid,
        output out_ready,
        input  out,
        input  count
    );

    modport slave (
        input  flush,
        input  hold,
        input  in_valid,
        output in_ready,
        input  in,
        output out_valid,
        input  out_ready,
        output out,
        output count
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Elastic pipeline stage register with a 2-entry skid buffer. Upstream and
// downstream stalls are decoupled: in_ready comes straight from a state bit,
// so there is no combinational path from out_ready, hold or in_valid back to
// in_ready.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   clear  synchronous active-high reset; zeroes control and data
//   bus    pipe_skid_reg_if.slave handshake bundle (flush, hold, in/out
//          valid/ready, payloads, occupancy count)
//
// Storage: main entry (r_out, valid = state bit 0) and skid entry
// (r_skid_d, valid = state bit 1). Priority: clear > flush > normal.
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  clear,
    pipe_skid_reg_if.slave        bus
);

    // Encoding chosen so bit0 = main entry valid, bit1 = skid entry valid.
    // That lets out_valid and in_ready come directly off flop outputs.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_out;
    logic [N-1:0] r_skid_d;

    logic         w_accept;
    logic         w_drain;
    logic         w_load_out_in;
    logic         w_load_out_skid;
    logic         w_load_skid;

    assign w_accept = bus.in_valid & ~r_state[1];
    assign w_drain  = r_state[0] & bus.out_ready & ~bus.hold;

    // State register
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Data registers: zeroed by clear, untouched by flush
    always_ff @(posedge clk) begin
        if (clear) begin
            r_out    <= '0;
            r_skid_d <= '0;
        end else if (!bus.flush) begin
            if (w_load_out_in) begin
                r_out <= bus.in;
            end else if (w_load_out_skid) begin
                r_out <= r_skid_d;
            end
            if (w_load_skid) begin
                r_skid_d <= bus.in;
            end
        end
    end

    // Next-state and data-load decode
    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        if (bus.flush) begin
            // An accept in this cycle still handshakes upstream but is dropped.
            w_state_nxt = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_load_out_in = 1'b1;
                        w_state_nxt   = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_out_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = FULL;
                    end else if (w_drain) begin
                        // out keeps its last value while invalid
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_drain) begin
                        w_load_out_skid = 1'b1;
                        w_state_nxt     = ONE;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Outputs, all taken directly from registers
    always_comb begin
        bus.out_valid = r_state[0];
        bus.in_ready  = ~r_state[1];
        bus.out       = r_out;
        bus.count     = {r_state[1], r_state[0] & ~r_state[1]};
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Directed vector table for pipe_skid_reg followed by a scoreboarded stream
// with mixed backpressure and hold.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;
    localparam int N  = 32;
    localparam int NV = 30;

    logic clk;
    logic clear;

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_skid_reg_if #(.N(N)) bus ();

    pipe_skid_reg #(.N(N)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    typedef struct {
        logic         clr;
        logic         fl;
        logic         hd;
        logic         iv;
        logic [N-1:0] din;
        logic         ordy;
        logic         e_ov;
        logic         e_ir;
        logic [N-1:0] e_out;
        logic [1:0]   e_cnt;
    } vec_t;

    vec_t vt [NV];

    function automatic vec_t mk(input logic clr, input logic fl, input logic hd,
                                input logic iv, input logic [N-1:0] din,
                                input logic ordy, input logic e_ov,
                                input logic e_ir, input logic [N-1:0] e_out,
                                input logic [1:0] e_cnt);
        vec_t v;
        v.clr = clr; v.fl = fl; v.hd = hd; v.iv = iv; v.din = din;
        v.ordy = ordy; v.e_ov = e_ov; v.e_ir = e_ir; v.e_out = e_out;
        v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk1(input string nm, input int row, input logic [N-1:0] got,
                        input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, got, exp);
        end
    endtask

    logic [N-1:0] sb_q[$];
    logic [N-1:0] exp_w;
    int           sent;
    int           rcvd;

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear         = 1'b1;
        bus.flush     = 1'b0;
        bus.hold      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;

        //            clr fl hd iv din    ordy ov ir out    cnt
        // reset
        vt[0]  = mk(1, 0, 0, 0, 32'h0,  0,   0, 1, 32'h0,  2'd0);
        // streaming 1..4, one word per cycle
        vt[1]  = mk(0, 0, 0, 1, 32'h1,  1,   1, 1, 32'h1,  2'd1);
        vt[2]  = mk(0, 0, 0, 1, 32'h2,  1,   1, 1, 32'h2,  2'd1);
        vt[3]  = mk(0, 0, 0, 1, 32'h3,  1,   1, 1, 32'h3,  2'd1);
        vt[4]  = mk(0, 0, 0, 1, 32'h4,  1,   1, 1, 32'h4,  2'd1);
        vt[5]  = mk(0, 0, 0, 0, 32'h0,  1,   0, 1, 32'h4,  2'd0);
        // skid / backpressure: A, B accepted, C held upstream
        vt[6]  = mk(0, 0, 0, 1, 32'hA,  0,   1, 1, 32'hA,  2'd1);
        vt[7]  = mk(0, 0, 0, 1, 32'hB,  0,   1, 0, 32'hA,  2'd2);
        vt[8]  = mk(0, 0, 0, 1, 32'hC,  0,   1, 0, 32'hA,  2'd2);
        vt[9]  = mk(0, 0, 0, 1, 32'hC,  1,   1, 1, 32'hB,  2'd1);
        vt[10] = mk(0, 0, 0, 1, 32'hC,  1,   1, 1, 32'hC,  2'd1);
        vt[11] = mk(0, 0, 0, 0, 32'h0,  1,   0, 1, 32'hC,  2'd0);
        // hold: 0x55 held at head, 0x66 goes to skid, then both drain
        vt[12] = mk(0, 0, 0, 1, 32'h55, 0,   1, 1, 32'h55, 2'd1);
        vt[13] = mk(0, 0, 1, 1, 32'h66, 1,   1, 0, 32'h55, 2'd2);
        vt[14] = mk(0, 0, 1, 0, 32'h0,  1,   1, 0, 32'h55, 2'd2);
        vt[15] = mk(0, 0, 1, 0, 32'h0,  1,   1, 0, 32'h55, 2'd2);
        vt[16] = mk(0, 0, 0, 0, 32'h0,  1,   1, 1, 32'h66, 2'd1);
        vt[17] = mk(0, 0, 0, 0, 32'h0,  1,   0, 1, 32'h66, 2'd0);
        // flush from FULL while 0x12 is offered
        vt[18] = mk(0, 0, 0, 1, 32'h10, 0,   1, 1, 32'h10, 2'd1);
        vt[19] = mk(0, 0, 0, 1, 32'h11, 0,   1, 0, 32'h10, 2'd2);
        vt[20] = mk(0, 1, 0, 1, 32'h12, 0,   0, 1, 32'h10, 2'd0);
        vt[21] = mk(0, 0, 0, 0, 32'h0,  1,   0, 1, 32'h10, 2'd0);
        // flush from EMPTY with an accept: word discarded
        vt[22] = mk(0, 1, 0, 1, 32'h13, 1,   0, 1, 32'h10, 2'd0);
        // simultaneous accept and drain
        vt[23] = mk(0, 0, 0, 1, 32'h7,  0,   1, 1, 32'h7,  2'd1);
        vt[24] = mk(0, 0, 0, 1, 32'h8,  1,   1, 1, 32'h8,  2'd1);
        vt[25] = mk(0, 0, 0, 0, 32'h0,  1,   0, 1, 32'h8,  2'd0);
        // clear from FULL with a handshake offered in the clear cycle
        vt[26] = mk(0, 0, 0, 1, 32'h20, 0,   1, 1, 32'h20, 2'd1);
        vt[27] = mk(0, 0, 0, 1, 32'h21, 0,   1, 0, 32'h20, 2'd2);
        vt[28] = mk(1, 0, 0, 1, 32'h22, 1,   0, 1, 32'h0,  2'd0);
        vt[29] = mk(0, 0, 0, 0, 32'h0,  0,   0, 1, 32'h0,  2'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            clear         = vt[i].clr;
            bus.flush     = vt[i].fl;
            bus.hold      = vt[i].hd;
            bus.in_valid  = vt[i].iv;
            bus.in        = vt[i].din;
            bus.out_ready = vt[i].ordy;
            @(posedge clk);
            #1;
            chk1("out_valid", i, N'(bus.out_valid), N'(vt[i].e_ov));
            chk1("in_ready",  i, N'(bus.in_ready),  N'(vt[i].e_ir));
            chk1("out",       i, bus.out,           vt[i].e_out);
            chk1("count",     i, N'(bus.count),     N'(vt[i].e_cnt));
        end

        // Scoreboarded stream: 16 words, irregular backpressure and hold.
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 300 && rcvd < 16; c++) begin
            @(negedge clk);
            clear         = 1'b0;
            bus.flush     = 1'b0;
            bus.in_valid  = (sent < 16) && (c % 5 != 3);
            bus.in        = 32'h100 + sent;
            bus.out_ready = (c % 3 != 0);
            bus.hold      = (c % 7 == 2);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(bus.in);
                sent++;
            end
            if (bus.out_valid && bus.out_ready && !bus.hold) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL stream_extra: got %h expected no word", bus.out);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk1("stream_word", rcvd, bus.out, exp_w);
                end
                rcvd++;
            end
            @(posedge clk);
        end
        chk1("stream_rcvd", 0, N'(rcvd), N'(16));
        #1;
        chk1("stream_count_end", 0, N'(bus.count), N'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
